// File: rtl/multiplier8bit16.sv
// Sequential shift-add multiplier: W x W -> 2W bits, one multiplier bit per clock.
// Define MUL_SIGNED_EN for two's-complement operands and product.
module multiplier8bit16 #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    output logic [2*W-1:0] res,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] res_q, res_d;

    logic [W:0]     partial;
    logic [2*W:0]   acc_sum;
    logic [2*W:0]   acc_step;
    logic [2*W-1:0] product;
    logic [2*W-1:0] final_res;
    logic [W-1:0]   cap1, cap2;

`ifdef MUL_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitudes fit W unsigned bits, including the most negative value.
    always_comb begin
        cap1      = op1[W-1] ? -op1 : op1;
        cap2      = op2[W-1] ? -op2 : op2;
        final_res = neg_q ? -product : product;
    end
`else
    always_comb begin
        cap1      = op1;
        cap2      = op2;
        final_res = product;
    end
`endif

    // Add multiplicand into the upper half (carry lands in the extra bit), then shift right.
    always_comb begin
        partial  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
        acc_sum  = mplier_q[0] ? {partial, acc_q[W-1:0]} : acc_q;
        acc_step = acc_sum >> 1;
        product  = acc_step[2*W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifdef MUL_SIGNED_EN
        neg_d    = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = cap1;
                    mplier_d = cap2;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MUL_SIGNED_EN
                    neg_d    = op1[W-1] ^ op2[W-1];
`endif
                    state_d  = StRun;
                end
            end
            StRun: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_d   = final_res;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
`ifdef MUL_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
`ifdef MUL_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    always_comb begin
        res  = res_q;
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

endmodule

// File: doc/multiplier8bit16.md
Name: multiplier8bit16

Overview:
Sequential shift-add multiplier, the inverse companion of the 16/8 divider. Takes an 8-bit multiplicand and an 8-bit multiplier and produces a 16-bit product. Typical use: rebuilding a dividend from quotient × divisor in the arithmetic datapath. Iterative, one bit per clock, with a start/busy/done handshake.

Parameters:
- W, 8, operand width in bits; product is 2*W bits. Only W=8 is verified; any other value must still elaborate.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- op1  input  W  multiplicand; captured on the accepting edge
- op2  input  W  multiplier; captured on the accepting edge
- res  output  2*W  product; valid from done onward, held until the next accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  single-cycle pulse marking res valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, res=0, busy=0, done=0, internal accumulator and bit counter cleared. No glitch-dependent release: all flops clear asynchronously and leave reset on the next clk edge with rst=1.
- States:
  - IDLE:
    - start=1 at edge E0 captures op1/op2 into internal registers, clears the accumulator, sets counter=0 and moves to RUN. busy=1 from after E0.
    - start=0 stays in IDLE.
  - RUN, edges E1..EW (8 edges for W=8):
    - If the current multiplier LSB is 1, add the multiplicand (left-aligned) into the 2W-bit accumulator.
    - Shift, then increment the counter.
    - After the edge where counter reaches W-1 (E8), load res and move to DONE.
  - DONE:
    - done=1 and busy=1 for exactly one cycle.
    - The next edge (E9) returns to IDLE with done=0 and busy=0.
- Latency: done is high during the cycle after E8, i.e. the 8th edge after the accepting edge. Minimum issue interval is 10 clocks (E0 to the next accepting edge at E10).
- Arithmetic: unsigned, exact, with no overflow possible (W+W to 2W bits). Carry out of each partial add is kept in the accumulator's extra bit.
- Start while busy (RUN or DONE) is ignored. Captured operands are unaffected, and changes on op1/op2 after E0 have no effect.
- res is not modified during RUN. It changes only on the E8 edge and on reset.
- Zero operands get no early-exit. Latency is always the fixed W+1 cycles.
- Reset asserted mid-RUN or in DONE aborts immediately: res=0 and done is never pulsed for the aborted operation.

Optional Feature:
- Macro MUL_SIGNED_EN.
- Defined: op1/op2 are two's complement and res is the two's-complement 2W-bit product.
  - Implemented by capturing magnitudes (|-128| = 128 in W bits unsigned) and a sign flag (op1[W-1] XOR op2[W-1]).
  - Run the same unsigned loop, then conditionally negate at the E8 load.
  - Latency is unchanged.
- Undefined: purely unsigned, with no sign logic synthesized.

Test Plan:
- Reset low for 2 cycles, then release -> res=0x0000, busy=0, done=0. Idle for 5 cycles -> done never pulses.
- op1=0x11, op2=0xAA, start pulsed 1 cycle -> done high exactly 8 edges after the accepting edge, res=0x0B4A, busy low again 1 cycle later.
- Boundary cases:
  - op1=0xFF, op2=0xFF -> res=0xFE01.
  - Back-to-back with op1=0x00, op2=0x55, start issued at the first allowed IDLE cycle -> res=0x0000 at its own done.
- Start held high for 12 cycles with operands changed to 0x03/0x04 at E3 -> only one product, 0x11×0xAA=0x0B4A, at E8. A second operation (0x03×0x04=0x000C) is accepted at E10.
- rst pulsed low at E4 of a 0x11×0xAA run -> res=0, busy=0, no done pulse. A following 0x02×0x03 gives res=0x0006.
- MUL_SIGNED_EN defined:
  - 0xFF×0x02 -> 0xFFFE
  - 0x80×0x80 -> 0x4000
  - 0x80×0x7F -> 0xC080
  - 0x00×0x80 -> 0x0000
